// File: rtl/clint_timer_mh_pkg.sv
// Shared definitions for the multi-hart CLINT timer: register offsets, address
// decode, bus FSM states and the byte-strobe merge helper.
package clint_timer_mh_pkg;

   localparam logic [15:0] MSIP_OFF     = 16'h0000;
   localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] MTIME_LO_OFF = 16'hBFF8;
   localparam logic [15:0] MTIME_HI_OFF = 16'hBFFC;
   localparam logic [31:0] WINDOW_SIZE  = 32'h0001_0000;
   localparam int          HART_W       = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } bus_state_e;

   typedef enum logic [2:0] {
      REG_NONE     = 3'd0,
      REG_MSIP     = 3'd1,
      REG_MTIMECMP = 3'd2,
      REG_MTIME_LO = 3'd3,
      REG_MTIME_HI = 3'd4
   } reg_kind_e;

   typedef struct packed {
      reg_kind_e         kind;
      logic [HART_W-1:0] hart;
      logic              hi;
   } reg_sel_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

   // Addresses below the base wrap to a huge offset, so one unsigned compare
   // rejects both sides of the window.
   function automatic reg_sel_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int          num_harts);
      logic [31:0] off;
      reg_sel_t    sel;
      off      = addr - base;
      sel.kind = REG_NONE;
      sel.hart = '0;
      sel.hi   = 1'b0;
      if (off < WINDOW_SIZE && off[1:0] == 2'b00) begin
         if (off[15:14] == MSIP_OFF[15:14]) begin
            if ({20'd0, off[13:2]} < 32'(num_harts)) begin
               sel.kind = REG_MSIP;
               sel.hart = off[5:2];
            end
         end else if (off[15:14] == MTIMECMP_OFF[15:14]) begin
            if ({21'd0, off[13:3]} < 32'(num_harts)) begin
               sel.kind = REG_MTIMECMP;
               sel.hart = off[6:3];
               sel.hi   = off[2];
            end
         end else if (off[15:0] == MTIME_LO_OFF) begin
            sel.kind = REG_MTIME_LO;
         end else if (off[15:0] == MTIME_HI_OFF) begin
            sel.kind = REG_MTIME_HI;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk down to the mtime tick; an mtime write freezes the divider for
// that cycle so the written value is not immediately incremented.
module clint_prescaler #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   output logic tick_o
);

   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!hold) begin
         cnt_q <= (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
      end
   end

   assign tick_o = (cnt_q == LAST) && !hold;

endmodule

// File: rtl/clint_timer_mh.sv
// Multi-hart core-local interruptor timer: 64-bit mtime with prescaler,
// per-hart mtimecmp/msip, valid/ready register bus with buffered response.
module clint_timer_mh
   import clint_timer_mh_pkg::*;
#(
   parameter int          NUM_HARTS   = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
   parameter int          TICK_DIV    = 1,
   parameter bit          HI_SNAPSHOT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bus_valid_i,
   output logic                 bus_ready_o,
   input  logic                 bus_we_i,
   input  logic [31:0]          bus_addr_i,
   input  logic [31:0]          bus_wdata_i,
   input  logic [3:0]           bus_wstrb_i,
   output logic                 bus_rvalid_o,
   input  logic                 bus_rready_i,
   output logic [31:0]          bus_rdata_o,
   output logic                 bus_err_o,
   output logic [NUM_HARTS-1:0] mtip_o,
   output logic [NUM_HARTS-1:0] msip_o,
   output logic [63:0]          mtime_o
);

   bus_state_e  state_q, state_d;
   reg_sel_t    dec;
   logic        accept;
   logic        wr_en;
   logic        wr_mtime_lo;
   logic        wr_mtime_hi;
   logic        tick;
   logic [63:0] mtime_q;
   logic [31:0] shadow_q;
   logic        last_lo_q;
   logic [31:0] rd_data;
   logic        rd_err;
   logic [31:0] hart_rd [NUM_HARTS];

   assign dec         = decode_addr(bus_addr_i, BASE_ADDR, NUM_HARTS);
   assign accept      = bus_valid_i && bus_ready_o;
   assign wr_en       = accept && bus_we_i;
   assign wr_mtime_lo = wr_en && (dec.kind == REG_MTIME_LO);
   assign wr_mtime_hi = wr_en && (dec.kind == REG_MTIME_HI);

   // ---------------- handshake FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      bus_ready_o  = 1'b0;
      bus_rvalid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus_ready_o = 1'b1;
            if (bus_valid_i) state_d = RESP;
         end
         RESP: begin
            bus_rvalid_o = 1'b1;
            if (bus_rready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- mtime ----------------
   clint_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .hold   (wr_mtime_lo || wr_mtime_hi),
      .tick_o (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q <= '0;
      end else if (wr_mtime_lo) begin
         mtime_q[31:0] <= merge_bytes(mtime_q[31:0], bus_wdata_i, bus_wstrb_i);
      end else if (wr_mtime_hi) begin
         mtime_q[63:32] <= merge_bytes(mtime_q[63:32], bus_wdata_i, bus_wstrb_i);
      end else if (tick) begin
         mtime_q <= mtime_q + 64'd1;
      end
   end

   assign mtime_o = mtime_q;

   // Shadow lets software read a coherent 64-bit mtime as lo-then-hi.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= '0;
         last_lo_q <= 1'b0;
      end else if (accept) begin
         last_lo_q <= !bus_we_i && (dec.kind == REG_MTIME_LO);
         if (HI_SNAPSHOT && !bus_we_i && dec.kind == REG_MTIME_LO) begin
            shadow_q <= mtime_q[63:32];
         end
      end
   end

   // ---------------- per-hart registers and compare ----------------
   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      logic        sel;
      logic [63:0] cmp_q;
      logic        msip_q;
      logic        mtip_q;

      assign sel = (dec.hart == HART_W'(h));

      always_ff @(posedge clk) begin
         if (rst) begin
            cmp_q  <= '1;
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
         end else begin
            if (wr_en && sel && dec.kind == REG_MTIMECMP) begin
               if (dec.hi) cmp_q[63:32] <= merge_bytes(cmp_q[63:32], bus_wdata_i, bus_wstrb_i);
               else        cmp_q[31:0]  <= merge_bytes(cmp_q[31:0], bus_wdata_i, bus_wstrb_i);
            end
            if (wr_en && sel && dec.kind == REG_MSIP && bus_wstrb_i[0]) begin
               msip_q <= bus_wdata_i[0];
            end
            mtip_q <= (mtime_q >= cmp_q);
         end
      end

      assign hart_rd[h] = !sel                        ? 32'd0 :
                          (dec.kind == REG_MSIP)      ? {31'd0, msip_q} :
                          (dec.kind == REG_MTIMECMP)  ? (dec.hi ? cmp_q[63:32] : cmp_q[31:0]) :
                                                        32'd0;
      assign msip_o[h]  = msip_q;
      assign mtip_o[h]  = mtip_q;
   end

   // ---------------- read mux and response buffer ----------------
   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      unique case (dec.kind)
         REG_MSIP, REG_MTIMECMP: begin
            for (int h = 0; h < NUM_HARTS; h++) rd_data = rd_data | hart_rd[h];
         end
         REG_MTIME_LO: rd_data = mtime_q[31:0];
         REG_MTIME_HI: rd_data = (HI_SNAPSHOT && last_lo_q) ? shadow_q : mtime_q[63:32];
         default:      rd_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_rdata_o <= '0;
         bus_err_o   <= 1'b0;
      end else if (accept) begin
         bus_rdata_o <= bus_we_i ? 32'd0 : rd_data;
         bus_err_o   <= rd_err;
      end
   end

endmodule

// File: tb/tb_clint_timer_mh.sv
// Directed bench for clint_timer_mh: a TICK_DIV=1 and a TICK_DIV=4 instance
// share one bus; a vector table plus hand sequences for timing corners.
module tb_clint_timer_mh;

   localparam logic [31:0] B = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_valid, bus_we, bus_rready;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;

   logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [1:0]  a_mtip, a_msip, b_mtip, b_msip;
   logic [63:0] a_mtime, b_mtime;

   int          n_vec = 0;
   int          n_bad = 0;
   int unsigned cyc;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   clint_timer_mh #(.NUM_HARTS(2), .BASE_ADDR(B), .TICK_DIV(1), .HI_SNAPSHOT(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .bus_valid_i(bus_valid), .bus_ready_o(a_ready), .bus_we_i(bus_we),
      .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata), .bus_wstrb_i(bus_wstrb),
      .bus_rvalid_o(a_rvalid), .bus_rready_i(bus_rready), .bus_rdata_o(a_rdata),
      .bus_err_o(a_err), .mtip_o(a_mtip), .msip_o(a_msip), .mtime_o(a_mtime)
   );

   clint_timer_mh #(.NUM_HARTS(2), .BASE_ADDR(B), .TICK_DIV(4), .HI_SNAPSHOT(1'b1)) dut_b (
      .clk(clk), .rst(rst),
      .bus_valid_i(bus_valid), .bus_ready_o(b_ready), .bus_we_i(bus_we),
      .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata), .bus_wstrb_i(bus_wstrb),
      .bus_rvalid_o(b_rvalid), .bus_rready_i(bus_rready), .bus_rdata_o(b_rdata),
      .bus_err_o(b_err), .mtip_o(b_mtip), .msip_o(b_msip), .mtime_o(b_mtime)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [1:0]  exp_msip;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the FSM idle; returns at the negedge after accept.
   task automatic send(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
      bus_valid = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      bus_wstrb = wstrb;
      @(negedge clk);
      bus_valid = 1'b0;
   endtask

   task automatic collect(output logic [31:0] rd, output logic err);
      int g = 0;
      while (a_rvalid !== 1'b1 && g < 8) begin
         @(negedge clk);
         g++;
      end
      check("rvalid after accept", a_rvalid, 1'b1);
      rd         = a_rdata;
      err        = a_err;
      bus_rready = 1'b1;
      @(negedge clk);
      bus_rready = 1'b0;
   endtask

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output logic [31:0] rd, output logic err);
      send(we, addr, wdata, wstrb);
      collect(rd, err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, held;
      logic        er;
      int          g;

      rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; bus_rready = 1'b0;
      bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;

      vecs[0]  = '{1'b1, B + 32'h0004, 32'h1,         4'b0001, 32'h0,         1'b0, 2'b10};
      vecs[1]  = '{1'b0, B + 32'h0004, 32'h0,         4'b0000, 32'h1,         1'b0, 2'b10};
      vecs[2]  = '{1'b1, B + 32'h0004, 32'h0,         4'b0010, 32'h0,         1'b0, 2'b10};
      vecs[3]  = '{1'b1, B + 32'h0000, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b0, 2'b11};
      vecs[4]  = '{1'b0, B + 32'h0000, 32'h0,         4'b0000, 32'h1,         1'b0, 2'b11};
      vecs[5]  = '{1'b1, B + 32'h0008, 32'h1,         4'b0001, 32'h0,         1'b1, 2'b11};
      vecs[6]  = '{1'b0, B + 32'h0008, 32'h0,         4'b0000, 32'h0,         1'b1, 2'b11};
      vecs[7]  = '{1'b1, B + 32'h0004, 32'h0,         4'b0001, 32'h0,         1'b0, 2'b01};
      vecs[8]  = '{1'b1, B + 32'h4008, 32'h1234_5678, 4'b1111, 32'h0,         1'b0, 2'b01};
      vecs[9]  = '{1'b1, B + 32'h4008, 32'hAABB_CCDD, 4'b0100, 32'h0,         1'b0, 2'b01};
      vecs[10] = '{1'b0, B + 32'h4008, 32'h0,         4'b0000, 32'h12BB_5678, 1'b0, 2'b01};
      vecs[11] = '{1'b0, B + 32'h400C, 32'h0,         4'b0000, 32'hFFFF_FFFF, 1'b0, 2'b01};
      vecs[12] = '{1'b0, B + 32'h4010, 32'h0,         4'b0000, 32'h0,         1'b1, 2'b01};
      vecs[13] = '{1'b0, B + 32'hBFF9, 32'h0,         4'b0000, 32'h0,         1'b1, 2'b01};
      vecs[14] = '{1'b0, B + 32'h1_0000, 32'h0,       4'b0000, 32'h0,         1'b1, 2'b01};
      vecs[15] = '{1'b0, 32'h01FF_FFFC, 32'h0,        4'b0000, 32'h0,         1'b1, 2'b01};
      vecs[16] = '{1'b1, B + 32'h1000, 32'h1,         4'b1111, 32'h0,         1'b1, 2'b01};
      vecs[17] = '{1'b1, B + 32'hBFF0, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1, 2'b01};
      vecs[18] = '{1'b0, B + 32'h0004, 32'h0,         4'b0000, 32'h0,         1'b0, 2'b01};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset ready",  a_ready,  1'b1);
      check("reset rvalid", a_rvalid, 1'b0);
      check("reset rdata",  a_rdata,  32'h0);
      check("reset err",    a_err,    1'b0);
      check("reset mtime",  a_mtime,  64'h0);
      check("reset mtip",   a_mtip,   2'b00);
      check("reset msip",   a_msip,   2'b00);

      // mtime lo read accepted on the first edge out of reset sees 0
      bus_valid = 1'b1; bus_we = 1'b0; bus_addr = B + 32'hBFF8; bus_wstrb = 4'b0000;
      rst = 1'b0;
      @(negedge clk);
      bus_valid = 1'b0;
      check("first mtime lo rdata (div4)", b_rdata, 32'h0);
      collect(rd, er);
      check("first mtime lo rdata", rd, 32'h0);
      check("first mtime lo err",   er, 1'b0);
      access(1'b0, B + 32'h4004, 32'h0, 4'b0000, rd, er);
      check("mtimecmp0 hi reset", rd, 32'hFFFF_FFFF);
      check("mtimecmp0 hi err",   er, 1'b0);
      check("mtip after reset",   b_mtip, 2'b00);

      // TICK_DIV=4: ten ticks in forty cycles
      g = 0;
      while (cyc < 40 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("div4 mtime at 40 cycles", b_mtime, 64'd10);

      // Carry from lo into hi
      access(1'b1, B + 32'hBFFC, 32'h0, 4'b1111, rd, er);
      send(1'b1, B + 32'hBFF8, 32'hFFFF_FFFF, 4'b1111);
      check("mtime lo write no tick", b_mtime, 64'h0_FFFF_FFFF);
      collect(rd, er);
      g = 0;
      while (b_mtime == 64'h0_FFFF_FFFF && g < 10) begin
         @(negedge clk);
         g++;
      end
      check("mtime carry into hi", b_mtime, 64'h1_0000_0000);

      // Compare: mtip rises one cycle after mtime reaches mtimecmp
      access(1'b1, B + 32'h4000, 32'd20, 4'b1111, rd, er);
      access(1'b1, B + 32'h4004, 32'd0,  4'b1111, rd, er);
      access(1'b1, B + 32'hBFFC, 32'd0,  4'b1111, rd, er);
      send(1'b1, B + 32'hBFF8, 32'd18, 4'b1111);
      check("mtime written to 18", a_mtime, 64'd18);
      collect(rd, er);
      g = 0;
      while (a_mtime != 64'd20 && g < 10) begin
         @(negedge clk);
         g++;
      end
      check("mtime reaches 20", a_mtime, 64'd20);
      check("mtip low when mtime==cmp", a_mtip[0], 1'b0);
      @(negedge clk);
      check("mtip high next cycle", a_mtip[0], 1'b1);
      send(1'b1, B + 32'h4004, 32'd1, 4'b1111);
      check("mtip still high at cmp write", a_mtip[0], 1'b1);
      collect(rd, er);
      check("mtip falls after cmp hi write", a_mtip[0], 1'b0);

      // Register-file vectors
      foreach (vecs[i]) begin
         access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er);
         check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d err", i),   er, vecs[i].exp_err);
         check($sformatf("vec%0d msip", i),  a_msip, vecs[i].exp_msip);
      end
      check("mtip hart1 stays low", a_mtip[1], 1'b0);

      // Snapshot of mtime hi, with response backpressure while held
      access(1'b1, B + 32'hBFFC, 32'h0, 4'b1111, rd, er);
      send(1'b1, B + 32'hBFF8, 32'hFFFF_FFFE, 4'b1111);
      collect(rd, er);
      send(1'b0, B + 32'hBFF8, 32'h0, 4'b0000);
      check("snapshot lo read", a_rdata, 32'hFFFF_FFFF);
      held = a_rdata;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("backpressure rvalid held", a_rvalid, 1'b1);
         check("backpressure rdata held",  a_rdata,  held);
         check("backpressure ready low",   a_ready,  1'b0);
      end
      collect(rd, er);
      access(1'b0, B + 32'hBFFC, 32'h0, 4'b0000, rd, er);
      check("hi read returns shadow", rd, 32'h0);
      check("live mtime hi",          a_mtime[63:32], 32'h1);
      access(1'b0, B + 32'hBFFC, 32'h0, 4'b0000, rd, er);
      check("second hi read is live", rd, 32'h1);

      // Error response held under backpressure, then reset mid-response
      send(1'b0, B + 32'h0008, 32'h0, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         check("err resp rvalid held", a_rvalid, 1'b1);
         check("err resp err held",    a_err,    1'b1);
         check("err resp rdata zero",  a_rdata,  32'h0);
         check("err resp ready low",   a_ready,  1'b0);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      check("reset drops rvalid", a_rvalid, 1'b0);
      check("reset restores ready", a_ready, 1'b1);
      check("reset clears err", a_err, 1'b0);
      check("reset clears msip", a_msip, 2'b00);
      rst = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
